// File: rtl/spif_router_pkg.sv
// Shared types and helpers for the multicast packet router.
package spif_router_pkg;
  localparam int KEY_BITS         = 32;
  localparam int PKT_BITS_DEF     = 72;
  localparam int NUM_CHANNELS_DEF = 4;

  typedef logic [PKT_BITS_DEF-1:0]     pkt_t;
  typedef logic [NUM_CHANNELS_DEF-1:0] route_t;

  // Increment holding at the all-ones value of a `bits`-wide counter (1..64).
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned bits);
    logic [63:0] lim;
    lim = {64{1'b1}} >> (7'd64 - 7'(bits));
    return (v >= lim) ? lim : v + 64'd1;
  endfunction
endpackage

// File: rtl/pkt_rt_lookup.sv
// Combinational key/mask priority match; lowest hitting entry supplies the route.
module pkt_rt_lookup
  import spif_router_pkg::*;
#(
  parameter int NUM_RREGS    = 16,
  parameter int NUM_CHANNELS = 4
) (
  input  logic [KEY_BITS-1:0]                         i_key,
  input  logic [NUM_RREGS-1:0][KEY_BITS-1:0]          i_reg_key,
  input  logic [NUM_RREGS-1:0][KEY_BITS-1:0]          i_reg_mask,
  input  logic [NUM_RREGS-1:0][NUM_CHANNELS-1:0]      i_reg_route,
  output logic                                        o_hit,
  output logic [NUM_CHANNELS-1:0]                     o_route
);
  // Scan high to low so the lowest matching index overwrites last.
  always_comb begin
    o_hit   = 1'b0;
    o_route = '0;
    for (int i = NUM_RREGS - 1; i >= 0; i--) begin
      if ((i_key & i_reg_mask[i]) == i_reg_key[i]) begin
        o_hit   = 1'b1;
        o_route = i_reg_route[i];
      end
    end
  end
endmodule

// File: rtl/pkt_mc_router.sv
// Two-stage multicast router: table lookup, then per-channel replication with
// a drop timer and saturating route/drop counters.
module pkt_mc_router
  import spif_router_pkg::*;
#(
  parameter int NUM_RREGS    = 16,
  parameter int NUM_CHANNELS = 4,
  parameter int PKT_BITS     = 72,
  parameter int KEY_LSB      = 8,
  parameter int CNT_BITS     = 32
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [31:0]                             drop_wait_in,
  input  logic [NUM_RREGS-1:0][KEY_BITS-1:0]      reg_key_in,
  input  logic [NUM_RREGS-1:0][KEY_BITS-1:0]      reg_mask_in,
  input  logic [NUM_RREGS-1:0][NUM_CHANNELS-1:0]  reg_route_in,
  input  logic [PKT_BITS-1:0]                     pkt_in_data_in,
  input  logic                                    pkt_in_vld_in,
  output logic                                    pkt_in_rdy_out,
  output logic [NUM_CHANNELS-1:0][PKT_BITS-1:0]   pkt_out_data_out,
  output logic [NUM_CHANNELS-1:0]                 pkt_out_vld_out,
  input  logic [NUM_CHANNELS-1:0]                 pkt_out_rdy_in,
  output logic [CNT_BITS-1:0]                     rt_cnt_out,
  output logic [CNT_BITS-1:0]                     drop_cnt_out
);
  function automatic logic [CNT_BITS-1:0] cnt_inc(input logic [CNT_BITS-1:0] v);
    return CNT_BITS'(sat_inc(64'(v), CNT_BITS));
  endfunction

  logic                    r_s1_full;
  logic [PKT_BITS-1:0]     r_s1_pkt;
  logic [NUM_CHANNELS-1:0] r_s1_route;
  logic [PKT_BITS-1:0]     r_s2_pkt;
  logic [NUM_CHANNELS-1:0] r_pend;
  logic [31:0]             r_timer;
  logic [CNT_BITS-1:0]     r_rt_cnt, r_drop_cnt;

  logic                    w_hit;
  logic [NUM_CHANNELS-1:0] w_route, w_pend_hs, w_pend_nx;
  logic                    w_timeout, w_s2_free, w_s1_drop, w_s2_load, w_s1_moves;
  logic                    w_accept, w_done;
  logic [CNT_BITS-1:0]     w_drop_1, w_drop_nx;

  pkt_rt_lookup #(.NUM_RREGS(NUM_RREGS), .NUM_CHANNELS(NUM_CHANNELS)) u_lookup (
    .i_key      (pkt_in_data_in[KEY_LSB +: KEY_BITS]),
    .i_reg_key  (reg_key_in),
    .i_reg_mask (reg_mask_in),
    .i_reg_route(reg_route_in),
    .o_hit      (w_hit),
    .o_route    (w_route)
  );

  // A handshake on the last pending copy beats the timeout in the same cycle.
  assign w_pend_hs  = r_pend & ~pkt_out_rdy_in;
  assign w_timeout  = (drop_wait_in != 32'd0) && (r_timer == drop_wait_in) && (w_pend_hs != '0);
  assign w_pend_nx  = w_timeout ? '0 : w_pend_hs;
  assign w_done     = (r_pend != '0) && (w_pend_hs == '0);
  assign w_s2_free  = (w_pend_nx == '0);

  assign w_s1_drop  = r_s1_full && (r_s1_route == '0);
  assign w_s2_load  = r_s1_full && !w_s1_drop && w_s2_free;
  assign w_s1_moves = w_s1_drop || w_s2_load;

  assign pkt_in_rdy_out = reset && (!r_s1_full || w_s1_moves);
  assign w_accept       = pkt_in_vld_in && pkt_in_rdy_out;

  // Both drop sources can fire together and each counts once.
  assign w_drop_1  = (w_s1_drop || w_timeout) ? cnt_inc(r_drop_cnt) : r_drop_cnt;
  assign w_drop_nx = (w_s1_drop && w_timeout) ? cnt_inc(w_drop_1) : w_drop_1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_s1_full  <= 1'b0;
      r_s1_pkt   <= '0;
      r_s1_route <= '0;
      r_s2_pkt   <= '0;
      r_pend     <= '0;
      r_timer    <= '0;
      r_rt_cnt   <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_s1_pkt   <= pkt_in_data_in;
        r_s1_route <= w_hit ? w_route : '0;
      end
      r_s1_full <= w_accept || (r_s1_full && !w_s1_moves);
      if (w_s2_load) begin
        r_s2_pkt <= r_s1_pkt;
        r_pend   <= r_s1_route;
        r_timer  <= '0;
      end else begin
        r_pend <= w_pend_nx;
        if (w_pend_nx != '0) r_timer <= r_timer + 32'd1;
      end
      if (w_done) r_rt_cnt <= cnt_inc(r_rt_cnt);
      r_drop_cnt <= w_drop_nx;
    end
  end

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_out
    assign pkt_out_data_out[c] = r_s2_pkt;
  end
  assign pkt_out_vld_out = r_pend;
  assign rt_cnt_out      = r_rt_cnt;
  assign drop_cnt_out    = r_drop_cnt;
endmodule
